// File: rtl/fifo36k_pkg.sv
// -----------------------------------------------------------------------------
// fifo36k_pkg
// Shared definitions for the synchronous FIFO36K controller:
//   - controller state encoding (RST, INIT, RUN)
//   - number of INIT cycles between reset release and normal operation
//   - default geometry and programmable-flag thresholds
//   - helpers mapping BRAM data width to the matching address width
// -----------------------------------------------------------------------------
package fifo36k_pkg;

    typedef enum logic [1:0] {
        RST  = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Cycles spent in INIT before the FIFO starts accepting requests.
    localparam int INIT_CYCLES = 2;

    // 1024 x 36 is the native FIFO36K geometry.
    localparam int DEF_ADDR_WIDTH        = 10;
    localparam int DEF_PROG_EMPTY_THRESH = 4;
    localparam int DEF_PROG_FULL_THRESH  = 1018;

    // Address width that a 36Kb array offers for a given data width.
    // Returns 0 for widths the primitive does not support.
    function automatic int addr_width_for_data(input int data_width);
        int aw;
        case (data_width)
            72:      aw = 9;
            36:      aw = 10;
            18:      aw = 11;
            9:       aw = 12;
            4:       aw = 13;
            2:       aw = 14;
            1:       aw = 15;
            default: aw = 0;
        endcase
        return aw;
    endfunction

    // True when the address width matches one of the supported aspect ratios.
    function automatic bit addr_width_legal(input int aw);
        return (aw >= 9) && (aw <= 15);
    endfunction

endpackage

// File: rtl/fifo36k_flag_gen.sv
// -----------------------------------------------------------------------------
// fifo36k_flag_gen
// Purely combinational status-flag decode from the next-cycle occupancy.
// The caller registers the results, so the flags describe the occupancy
// that will hold after the coming clock edge.
//
// Ports:
//   i_count_next         occupancy after the coming edge, 0..DEPTH
//   i_prog_empty_thresh  o_prog_empty while count <= this value
//   i_prog_full_thresh   o_prog_full while count >= this value
//   o_empty              count == 0
//   o_full               count == DEPTH
//   o_almost_empty       count <= 1
//   o_almost_full        count >= DEPTH-1
//   o_prog_empty         count <= i_prog_empty_thresh
//   o_prog_full          count >= i_prog_full_thresh
// -----------------------------------------------------------------------------
module fifo36k_flag_gen
    import fifo36k_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
)(
    input  logic [ADDR_WIDTH:0] i_count_next,
    input  logic [ADDR_WIDTH:0] i_prog_empty_thresh,
    input  logic [ADDR_WIDTH:0] i_prog_full_thresh,
    output logic                o_empty,
    output logic                o_full,
    output logic                o_almost_empty,
    output logic                o_almost_full,
    output logic                o_prog_empty,
    output logic                o_prog_full
);

    // DEPTH, DEPTH-1 and 1 expressed in the occupancy width.
    localparam logic [ADDR_WIDTH:0] C_DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] C_DEPTH_M1 = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] C_ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

    assign o_empty        = (i_count_next == '0);
    assign o_full         = (i_count_next == C_DEPTH);
    assign o_almost_empty = (i_count_next <= C_ONE);
    assign o_almost_full  = (i_count_next >= C_DEPTH_M1);
    assign o_prog_empty   = (i_count_next <= i_prog_empty_thresh);
    assign o_prog_full    = (i_count_next >= i_prog_full_thresh);

endmodule

// File: rtl/fifo36k_sync_ctrl.sv
// -----------------------------------------------------------------------------
// fifo36k_sync_ctrl
// Pointer, flag and sequencing controller for a FIFO36K block RAM used with
// a single clock. Tracks occupancy, accepts or rejects requests, drives the
// BRAM write/read ports and produces the full flag set.
//
// Ports:
//   CLK         single clock, rising edge
//   RESET       synchronous reset, active-low
//   WR_EN       write request
//   RD_EN       read request
//   RAM_WE      accepted write this cycle (combinational)
//   RAM_WADDR   write pointer
//   RAM_RE      accepted read this cycle (combinational)
//   RAM_RADDR   read pointer
//   RD_VALID    BRAM read data valid, one cycle after RAM_RE
//   WORD_COUNT  occupancy, 0..DEPTH
//   EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, PROG_EMPTY, PROG_FULL
//               registered status flags
//   OVERFLOW    one-cycle pulse after a write request while FULL (RUN only)
//   UNDERFLOW   one-cycle pulse after a read request while EMPTY (RUN only)
// -----------------------------------------------------------------------------
module fifo36k_sync_ctrl
    import fifo36k_pkg::*;
#(
    parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
    parameter int PROG_EMPTY_THRESH = DEF_PROG_EMPTY_THRESH,
    parameter int PROG_FULL_THRESH  = DEF_PROG_FULL_THRESH
)(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WR_EN,
    input  logic                  RD_EN,
    output logic                  RAM_WE,
    output logic [ADDR_WIDTH-1:0] RAM_WADDR,
    output logic                  RAM_RE,
    output logic [ADDR_WIDTH-1:0] RAM_RADDR,
    output logic                  RD_VALID,
    output logic [ADDR_WIDTH:0]   WORD_COUNT,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  PROG_EMPTY,
    output logic                  PROG_FULL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ADDR_WIDTH:0]   cnt_t;

    localparam int INIT_CNT_W = $clog2(INIT_CYCLES + 1);
    typedef logic [INIT_CNT_W-1:0] init_cnt_t;

    localparam addr_t     ADDR_ONE      = addr_t'(1);
    localparam init_cnt_t INIT_CNT_ONE  = init_cnt_t'(1);
    localparam init_cnt_t INIT_CNT_LAST = init_cnt_t'(INIT_CYCLES - 1);
    localparam cnt_t      C_PE_THRESH   = cnt_t'(PROG_EMPTY_THRESH);
    localparam cnt_t      C_PF_THRESH   = cnt_t'(PROG_FULL_THRESH);

    // Reject illegal configurations while elaborating.
    generate
        if (!addr_width_legal(ADDR_WIDTH)) begin : g_bad_addr_width
            $error("fifo36k_sync_ctrl: ADDR_WIDTH must be 9..15");
        end
        if ((PROG_EMPTY_THRESH < 1) || (PROG_EMPTY_THRESH > DEPTH - 2)) begin : g_bad_pe_thresh
            $error("fifo36k_sync_ctrl: PROG_EMPTY_THRESH must be 1..DEPTH-2");
        end
        if ((PROG_FULL_THRESH < 2) || (PROG_FULL_THRESH > DEPTH - 1)) begin : g_bad_pf_thresh
            $error("fifo36k_sync_ctrl: PROG_FULL_THRESH must be 2..DEPTH-1");
        end
        if (PROG_EMPTY_THRESH >= PROG_FULL_THRESH) begin : g_bad_thresh_order
            $error("fifo36k_sync_ctrl: PROG_EMPTY_THRESH must be below PROG_FULL_THRESH");
        end
    endgenerate

    // Sequencing state
    state_e    r_state;
    state_e    w_state_next;
    init_cnt_t r_init_cnt;

    // Pointers, occupancy and registered outputs
    addr_t r_wptr;
    addr_t r_rptr;
    cnt_t  r_count;
    cnt_t  w_count_next;
    logic  r_rd_valid_p1;
    logic  r_overflow;
    logic  r_underflow;
    logic  r_empty;
    logic  r_full;
    logic  r_almost_empty;
    logic  r_almost_full;
    logic  r_prog_empty;
    logic  r_prog_full;

    // Request qualification
    logic w_run;
    logic w_wr_ok;
    logic w_rd_ok;

    // Flag decode of the next occupancy
    logic w_empty_c;
    logic w_full_c;
    logic w_almost_empty_c;
    logic w_almost_full_c;
    logic w_prog_empty_c;
    logic w_prog_full_c;

    // -------------------------------------------------------------------------
    // FSM state register. RESET low from any state returns to RST.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state    <= RST;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == INIT) begin
                r_init_cnt <= r_init_cnt + INIT_CNT_ONE;
            end else begin
                r_init_cnt <= '0;
            end
        end
    end

    // Next state and request qualification. Requests are only honoured in
    // RUN; against the registered flags, so FULL/EMPTY gate acceptance.
    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        w_wr_ok      = 1'b0;
        w_rd_ok      = 1'b0;
        case (r_state)
            RST: begin
                w_state_next = INIT;
            end
            INIT: begin
                if (r_init_cnt == INIT_CNT_LAST) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_run   = 1'b1;
                w_wr_ok = WR_EN & ~r_full;
                w_rd_ok = RD_EN & ~r_empty;
            end
            default: begin
                w_state_next = RST;
            end
        endcase
    end

    // Occupancy can never leave 0..DEPTH because wr_ok/rd_ok are gated by
    // FULL/EMPTY, so the unsigned add/subtract needs no saturation.
    assign w_count_next = r_count + cnt_t'(w_wr_ok) - cnt_t'(w_rd_ok);

    fifo36k_flag_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_flag_gen (
        .i_count_next        (w_count_next),
        .i_prog_empty_thresh (C_PE_THRESH),
        .i_prog_full_thresh  (C_PF_THRESH),
        .o_empty             (w_empty_c),
        .o_full              (w_full_c),
        .o_almost_empty      (w_almost_empty_c),
        .o_almost_full       (w_almost_full_c),
        .o_prog_empty        (w_prog_empty_c),
        .o_prog_full         (w_prog_full_c)
    );

    // -------------------------------------------------------------------------
    // Stage p0 -> p1: pointers, occupancy, flags, error pulses and the
    // read-data-valid strobe all register on the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_rd_valid_p1  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_empty        <= 1'b1;
            r_full         <= 1'b1;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_prog_empty   <= 1'b1;
            r_prog_full    <= 1'b0;
        end else begin
            // Pointers wrap naturally at DEPTH via ADDR_WIDTH truncation.
            if (w_wr_ok) begin
                r_wptr <= r_wptr + ADDR_ONE;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + ADDR_ONE;
            end
            r_count        <= w_count_next;
            r_rd_valid_p1  <= w_rd_ok;
            // Rejections outside RUN are silent.
            r_overflow     <= w_run & WR_EN & r_full;
            r_underflow    <= w_run & RD_EN & r_empty;
            r_empty        <= w_empty_c;
            // FULL is held high until the edge that enters RUN so nothing
            // can be written while the controller is still initialising.
            r_full         <= (w_state_next == RUN) ? w_full_c : 1'b1;
            r_almost_empty <= w_almost_empty_c;
            r_almost_full  <= w_almost_full_c;
            r_prog_empty   <= w_prog_empty_c;
            r_prog_full    <= w_prog_full_c;
        end
    end

    assign RAM_WE       = w_wr_ok;
    assign RAM_WADDR    = r_wptr;
    assign RAM_RE       = w_rd_ok;
    assign RAM_RADDR    = r_rptr;
    assign RD_VALID     = r_rd_valid_p1;
    assign WORD_COUNT   = r_count;
    assign EMPTY        = r_empty;
    assign FULL         = r_full;
    assign ALMOST_EMPTY = r_almost_empty;
    assign ALMOST_FULL  = r_almost_full;
    assign PROG_EMPTY   = r_prog_empty;
    assign PROG_FULL    = r_prog_full;
    assign OVERFLOW     = r_overflow;
    assign UNDERFLOW    = r_underflow;

endmodule
